// File: rtl/serial_tx.sv
// Serial frame transmitter: start bit, DATA_BITS data LSB first, optional odd parity, stop bit.
// Ports: clk, reset (sync, active-high), in_valid/in_data/in_ready handshake, txd line, busy, done pulse.
module serial_tx #(
  parameter int DATA_BITS = 8,
  parameter int PARITY_EN = 1
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 in_valid,
  input  logic [DATA_BITS-1:0] in_data,
  output logic                 in_ready,
  output logic                 txd,
  output logic                 busy,
  output logic                 done
);

  localparam int CW = (DATA_BITS > 1) ? $clog2(DATA_BITS) : 1;

  localparam logic [2:0] IDLE   = 3'd0;
  localparam logic [2:0] START  = 3'd1;
  localparam logic [2:0] DATA   = 3'd2;
  localparam logic [2:0] PARITY = 3'd3;
  localparam logic [2:0] STOP   = 3'd4;

  localparam logic [CW-1:0] LAST = CW'(DATA_BITS - 1);

  logic [2:0]           state, state_n;
  logic [DATA_BITS-1:0] shreg, shreg_n;
  logic [CW-1:0]        cnt, cnt_n;
  logic                 par, par_n;
  logic                 accept;
  logic                 txd_n, busy_n, done_n;

  assign in_ready = (state == IDLE) || (state == STOP);
  assign accept   = in_valid && in_ready;

  always_comb begin
    state_n = state;
    shreg_n = shreg;
    cnt_n   = cnt;
    par_n   = par;
    case (state)
      IDLE, STOP: begin
        state_n = IDLE;
        if (accept) begin
          state_n = START;
          shreg_n = in_data;
          par_n   = ~^in_data;
        end
      end
      START: begin
        state_n = DATA;
        cnt_n   = '0;
      end
      DATA: begin
        if (cnt == LAST) begin
          state_n = (PARITY_EN != 0) ? PARITY : STOP;
        end else begin
          // Shift on the way to the next data cycle so the
          // registered txd picks up the upcoming bit.
          cnt_n   = cnt + 1'b1;
          shreg_n = shreg >> 1;
        end
      end
      PARITY: state_n = STOP;
      default: state_n = IDLE;
    endcase
  end

  // Outputs are decoded from the next state and registered
  // alongside it, so they line up with the state they describe.
  always_comb begin
    txd_n  = 1'b1;
    busy_n = 1'b1;
    done_n = 1'b0;
    unique case (1'b1)
      (state_n == START):  txd_n  = 1'b0;
      (state_n == DATA):   txd_n  = shreg_n[0];
      (state_n == PARITY): txd_n  = par_n;
      (state_n == STOP):   done_n = 1'b1;
      default:             busy_n = 1'b0;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state <= IDLE;
      shreg <= '0;
      cnt   <= '0;
      par   <= 1'b0;
      txd   <= 1'b1;
      busy  <= 1'b0;
      done  <= 1'b0;
    end else begin
      state <= state_n;
      shreg <= shreg_n;
      cnt   <= cnt_n;
      par   <= par_n;
      txd   <= txd_n;
      busy  <= busy_n;
      done  <= done_n;
    end
  end

endmodule
